// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: op codes, FSM states,
// flag bit positions and the round-robin pick rule.
package alu_pkg;

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SHL = 2'b11;

  localparam int N = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int O = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // Winner id: a lone requester wins; under contention the one not served last wins.
  function automatic logic arb_pick(input logic r0, input logic r1, input logic last);
    logic pick;
    if (r0 && r1) begin
      pick = ~last;
    end else if (r1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: clear/add/sub/shift-left with {n,z,c,o} flags.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  logic [WIDTH:0] wide_s;

  // Result, carry/borrow and overflow for the selected operation.
  always_comb begin
    wide_s = {(WIDTH+1){1'b0}};
    flags  = 4'b0000;
    case (op)
      OP_ADD:  wide_s = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide_s = {1'b0, a} - {1'b0, b};
      // Shift amounts above WIDTH push every bit, carry included, out to zero.
      OP_SHL:  wide_s = {1'b0, a} << b;
      default: wide_s = {(WIDTH+1){1'b0}};
    endcase
    res = wide_s[WIDTH-1:0];
    if (op == OP_CLR) begin
      flags = 4'b0000;
    end else begin
      flags[N] = wide_s[WIDTH-1];
      flags[Z] = (wide_s[WIDTH-1:0] == {WIDTH{1'b0}});
      flags[C] = wide_s[WIDTH];
      case (op)
        OP_ADD:  flags[O] = (a[WIDTH-1] == b[WIDTH-1]) && (wide_s[WIDTH-1] != a[WIDTH-1]);
        OP_SUB:  flags[O] = (a[WIDTH-1] != b[WIDTH-1]) && (wide_s[WIDTH-1] != a[WIDTH-1]);
        default: flags[O] = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between execute (0) and branch/address (1)
// requesters; owns the architectural NZCO flag register.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             setf0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             setf1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags,
  output logic             busy
);

  state_t           state_r;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             setf_r;
  logic             id_r;
  logic             last_r;
  logic [WIDTH-1:0] res_r;
  logic [3:0]       flags_r;

  logic             any_req_s;
  logic             win_s;
  logic [WIDTH-1:0] alu_res_s;
  logic [3:0]       alu_flags_s;

  assign any_req_s = req0 | req1;
  assign win_s     = arb_pick(req0, req1, last_r);

  alu #(.WIDTH(WIDTH)) u_alu (
    .op    (op_r),
    .a     (a_r),
    .b     (b_r),
    .res   (alu_res_s),
    .flags (alu_flags_s)
  );

  // Arbitration, operand capture, execute and write-back sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      op_r    <= OP_CLR;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      setf_r  <= 1'b0;
      id_r    <= 1'b0;
      last_r  <= 1'b1;
      res_r   <= {WIDTH{1'b0}};
      flags_r <= 4'b0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            op_r    <= win_s ? op1 : op0;
            a_r     <= win_s ? a1 : a0;
            b_r     <= win_s ? b1 : b0;
            setf_r  <= win_s ? setf1 : setf0;
            id_r    <= win_s;
            last_r  <= win_s;
            state_r <= EXEC;
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          res_r <= alu_res_s;
          if (setf_r) begin
            flags_r <= alu_flags_s;
          end else begin
            flags_r <= flags_r;
          end
          state_r <= WB;
        end
        WB:      state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Grants are combinational and suppressed while reset is asserted.
  assign gnt0  = (state_r == IDLE) && !reset && any_req_s && !win_s;
  assign gnt1  = (state_r == IDLE) && !reset && any_req_s && win_s;
  assign done0 = (state_r == WB) && !id_r;
  assign done1 = (state_r == WB) && id_r;
  assign busy  = (state_r != IDLE);
  assign res   = res_r;
  assign flags = flags_r;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares the single combinational 32-bit `alu` between two requesters: requester 0 is the execute stage, requester 1 is the branch/address unit. Each requester uses a req/gnt/done handshake. The block arbitrates round-robin, registers the winner's operands, runs one ALU operation and registers the result. It also owns the architectural NZCO flag register, which is updated only by operations that request it.

## Interface
- `WIDTH`, 32, datapath width; only 32 is supported.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req0` / `req1`  in  1  request; held with operands stable until the matching `gnt`.
- `op0` / `op1`  in  2  operation: 00 clear, 01 add, 10 sub, 11 shift-left.
- `a0`, `b0` / `a1`, `b1`  in  WIDTH  operands.
- `setf0` / `setf1`  in  1  update the flag register with this operation's flags.
- `gnt0` / `gnt1`  out  1  one-cycle pulse; operands are captured at the end of this cycle.
- `done0` / `done1`  out  1  one-cycle pulse; `res` is valid in this cycle.
- `res`  out  WIDTH  registered result; holds until the next `done`.
- `flags`  out  4  registered {n,z,c,o}.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, EXEC, WB.
  - IDLE → EXEC when any req is high. Grant the winner: latch op/a/b/setf/id and update `last`.
  - IDLE stays in IDLE when no req is high.
  - EXEC → WB always. Latch the ALU result into `res`; if `setf` was latched, latch the ALU flags into `flags`.
  - WB → IDLE always. Pulse `done` for the latched id.
- `gnt` is combinational: asserted only in IDLE, for the winner only.
- `done` is asserted only in WB.
- Arbitration:
  - Exactly one req high: that requester wins.
  - Both req high: the requester not equal to `last` wins.
  - `last` resets to 1, so requester 0 wins the first contention.
- ALU semantics, with the 33-bit {c,res}:
  - add: {c,res} = a + b; n = res[31]; z = (res == 0); o = (a[31] == b[31]) && (res[31] != a[31]).
  - sub: {c,res} = a − b, where c is bit 32 of the 33-bit difference (1 when borrow); n and z as for add; o = (a[31] != b[31]) && (res[31] != a[31]).
  - shl: {c,res} = {1'b0,a} << b, using the full 32-bit b.
    - b = 0: c = 0.
    - 1 ≤ b ≤ 32: c = a[32−b].
    - b > 32: res = 0, c = 0.
    - n and z as for add; o = 0.
  - clear: res = 0 and all four flags = 0, including z = 0.
- With `setf` = 0, `flags` is unchanged; `res` is still written.
- A req that drops before its gnt is simply not served; no error is raised.

## Timing
- Grant in cycle t → `done` in cycle t+2.
- The next grant can occur at t+3 at the earliest, giving a throughput of 1 operation per 3 cycles.
- A requester keeping req high after gnt is treated as a new request, evaluated in the next IDLE.
- `res` and `flags` change only on the edge closing EXEC, so they are visible in the `done` cycle.
- Reset values: state IDLE, `gnt*` = 0, `done*` = 0, `res` = 0, `flags` = 0000, `busy` = 0, `last` = 1.
- Reset in EXEC or WB aborts the in-flight operation: no `done` is issued and `flags` is cleared.
- Reset dominates a simultaneous req; no gnt is issued in the reset cycle.

## Structure
- Shared package `alu_pkg` holds:
  - op encodings: OP_CLR = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_SHL = 2'b11.
  - the state enum {IDLE, EXEC, WB}.
  - flag bit indices: N = 3, Z = 2, C = 1, O = 0.
- Instantiate one sub-module, the existing `alu`, driven from the latched op/a/b registers. Do not duplicate the arithmetic.

## Test plan
- Single request: req0 with add, a = 0x7FFFFFFF, b = 1, setf = 1 → `gnt0` at t, `done0` at t+2, `res` = 0x80000000, `flags` = 1001.
- Contention: req0 and req1 held high together for 12 cycles → grants alternate 0, 1, 0, 1; each `done` arrives 2 cycles after its grant.
- `setf` = 0: sub with a = 5, b = 5 → `res` = 0 and `flags` keep their prior value. Repeat with `setf` = 1 → z = 1, c = 0.
- Shift boundaries, `setf` = 1:
  - a = 0x80000001, b = 1 → `res` = 0x00000002, c = 1.
  - b = 32 → `res` = 0, c = 1, z = 1.
  - b = 40 → `res` = 0, c = 0.
- Reset in EXEC after a grant → no `done`, `res` = 0, `flags` = 0000. The next req0 is granted in the first cycle after reset deasserts.
- Clear with `setf` = 1 after flags = 1111 → `res` = 0, `flags` = 0000.
